// File: rtl/hist_pkg.sv
// Shared definitions for the histogram request arbiter and its helpers.
package hist_pkg;

  localparam int BIN_W_DEF = 6;
  localparam int STAT_W    = 16;

  typedef enum logic [1:0] {
    ST_ARB       = 2'd0,
    ST_HOLD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  // Round-robin successor of a granted index.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/hist_req_arbiter_rr_picker.sv
// Rotating-priority one-hot picker: the first set request at or after
// i_ptr (wrapping) wins. Purely combinational.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  int w_k;

  // Walk offsets from farthest to nearest so the nearest request wins last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_k = (int'(i_ptr) + i) % N;
      if (i_req[w_k]) begin
        o_grant      = '0;
        o_grant[w_k] = 1'b1;
        o_idx        = PTR_W'(w_k);
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hist_req_arbiter.sv
// Round-robin arbiter sharing the histogram core's bin-increment port among
// NUM_REQ sources, with a one-entry output register and forced-dump
// sequencing. Optional grant statistics: define HIST_ARB_STATS_EN.
module hist_req_arbiter
  import hist_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BIN_W   = BIN_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*BIN_W-1:0] req_bin,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     hist_wr_en,
  output logic [BIN_W-1:0]         hist_wr_bin,
  input  logic                     hist_ready,
  output logic                     hist_dump,
  input  logic                     dump_req,
  output logic                     dump_done,
  input  logic [2:0]               stat_sel,
  output logic [STAT_W-1:0]        stat_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       r_state, w_state_nxt;
  logic [PTR_W-1:0] r_rr_ptr;
  logic             r_wr_en;
  logic [BIN_W-1:0] r_wr_bin;
  logic             r_run;        // low for the first edge after reset so req_ready stays 0 in reset
  logic             r_dump_armed; // set while dump_req is low; a dump consumes it

  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_any;
  logic [BIN_W-1:0]   w_pick_bin;
  logic               w_accept, w_space, w_dump_start, w_grant_en, w_grant;

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_onehot),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_accept     = r_wr_en && hist_ready;
  assign w_space      = !r_wr_en || w_accept;
  assign w_dump_start = (r_state == ST_ARB) && dump_req && r_dump_armed;
  assign w_grant_en   = r_run && (r_state == ST_ARB) && w_space && !w_dump_start;
  assign w_grant      = w_grant_en && w_pick_any;
  assign w_pick_bin   = req_bin[w_pick_idx*BIN_W +: BIN_W];

  assign req_ready   = w_grant_en ? w_pick_onehot : '0;
  assign hist_wr_en  = r_wr_en;
  assign hist_wr_bin = r_wr_bin;

  // Dump sequencing next-state and its one-cycle pulses.
  always_comb begin
    w_state_nxt = r_state;
    hist_dump   = 1'b0;
    dump_done   = 1'b0;
    case (r_state)
      ST_ARB:       if (w_dump_start) w_state_nxt = ST_HOLD;
      ST_HOLD:      if (!r_wr_en) begin
                      hist_dump   = 1'b1;
                      w_state_nxt = ST_WAIT_BUSY;
                    end
      ST_WAIT_BUSY: if (!hist_ready) w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (hist_ready) begin
                      dump_done   = 1'b1;
                      w_state_nxt = ST_ARB;
                    end
      default:      w_state_nxt = ST_ARB;
    endcase
  end

  // State, pointer, dump arming and the one-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ARB;
      r_rr_ptr     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_bin     <= '0;
      r_run        <= 1'b0;
      r_dump_armed <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_dump_start)  r_dump_armed <= 1'b0;
      else if (!dump_req) r_dump_armed <= 1'b1;
      if (w_grant) begin
        r_wr_en  <= 1'b1;
        r_wr_bin <= w_pick_bin;
        r_rr_ptr <= PTR_W'(rr_next(int'(w_pick_idx), NUM_REQ));
      end else if (w_accept) begin
        r_wr_en <= 1'b0;
      end
    end
  end

`ifdef HIST_ARB_STATS_EN
  logic [STAT_W-1:0] r_cnt [NUM_REQ];
  logic [STAT_W-1:0] r_stat_cnt;
  logic [STAT_W-1:0] w_stat_mux;

  // Select the requested counter; out-of-range selects read as zero.
  always_comb begin
    w_stat_mux = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (int'(stat_sel) == k) w_stat_mux = r_cnt[k];
  end

  // Saturating per-requester grant counters, cleared by a completed dump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these counters are a handful of flops, not a RAM, so an async reset is cheap and required.
      for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= '0;
      r_stat_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (dump_done)
          r_cnt[k] <= '0;
        else if (req_valid[k] && req_ready[k] && (r_cnt[k] != '1))
          r_cnt[k] <= r_cnt[k] + 1'b1;
      end
      r_stat_cnt <= w_stat_mux;
    end
  end

  assign stat_cnt = r_stat_cnt;
`else
  logic w_unused_stat_sel;
  assign w_unused_stat_sel = ^stat_sel;
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_hist_req_arbiter.sv
// Randomized + directed bench for hist_req_arbiter against a transaction-level
// reference model (queue for the output entry, integer pointer, dump phase).
module tb_hist_req_arbiter;

  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_bin;
  logic [N-1:0]   req_ready;
  logic           hist_wr_en;
  logic [W-1:0]   hist_wr_bin;
  logic           hist_ready;
  logic           hist_dump;
  logic           dump_req;
  logic           dump_done;
  logic [2:0]     stat_sel;
  logic [15:0]    stat_cnt;

  hist_req_arbiter #(.NUM_REQ(N), .BIN_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .hist_wr_en(hist_wr_en), .hist_wr_bin(hist_wr_bin),
    .hist_ready(hist_ready), .hist_dump(hist_dump), .dump_req(dump_req),
    .dump_done(dump_done), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state.
  bit m_run;
  int m_ptr;
  int m_q[$];      // pending increment (at most one entry)
  int m_phase;     // 0 arbitrate, 1 hold, 2 await busy, 3 await done
  bit m_armed;
  int m_cnt[N];
  int m_stat;

  task automatic model_reset();
    m_run = 0; m_ptr = 0; m_q.delete(); m_phase = 0; m_armed = 1; m_stat = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] b,
                      input logic hr, input logic dr, input logic [2:0] sel);
    int g;
    bit acc, space, start, e_dump, e_done;
    logic [N-1:0] e_ready;
    @(negedge clk);
    req_valid = v; req_bin = b; hist_ready = hr; dump_req = dr; stat_sel = sel;
    #1;
    acc    = (m_q.size() != 0) && hr;
    space  = (m_q.size() == 0) || acc;
    start  = (m_phase == 0) && dr && m_armed;
    e_dump = (m_phase == 1) && (m_q.size() == 0);
    e_done = (m_phase == 3) && hr;
    g = -1;
    if (m_run && m_phase == 0 && space && !start)
      for (int i = 0; i < N; i++) begin
        int k = (m_ptr + i) % N;
        if (g < 0 && v[k]) g = k;
      end
    e_ready = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", req_ready, e_ready);
    check("hist_wr_en", hist_wr_en, m_q.size() != 0);
    if (m_q.size() != 0) check("hist_wr_bin", hist_wr_bin, m_q[0]);
    check("hist_dump", hist_dump, e_dump);
    check("dump_done", dump_done, e_done);
    check("stat_cnt", stat_cnt, m_stat);
`ifdef HIST_ARB_STATS_EN
    m_stat = (sel < N) ? m_cnt[sel] : 0;
`endif
    if (acc) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(int'(b[g*W +: W]));
      m_ptr = (g + 1) % N;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end
    case (m_phase)
      0: if (start) m_phase = 1;
      1: if (e_dump) m_phase = 2;
      2: if (!hr) m_phase = 3;
      default: if (hr) begin
        m_phase = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
    endcase
    if (start) m_armed = 0;
    else if (!dr) m_armed = 1;
    m_run = 1;
  endtask

  // Async reset mid-cycle with requests pending; outputs must clear at once.
  task automatic do_reset();
    req_valid = '1; hist_ready = 1'b1; dump_req = 1'b0; stat_sel = 3'd0;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_en", hist_wr_en, 0);
    check("rst_wr_bin", hist_wr_bin, 0);
    check("rst_dump", hist_dump, 0);
    check("rst_done", dump_done, 0);
    check("rst_stat", stat_cnt, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // The first edge after release only wakes the arbiter; grants start after it.
    m_run = 1;
  endtask

  logic [N*W-1:0] b1, b3;
  logic           dr_lvl;

  initial begin
    req_valid = '0; req_bin = '0; hist_ready = 1'b1; dump_req = 1'b0; stat_sel = '0;
    rst_n = 1'b1;
    #2;
    do_reset();

    // Everyone requesting: grants rotate 0,1,2,3,0 and bins follow a cycle later.
    b1 = {6'd4, 6'd3, 6'd2, 6'd1};
    for (int i = 0; i < 5; i++) begin
      step('1, b1, 1'b1, 1'b0, 3'd0);
      check("s1_grant", req_ready, N'(1) << (i % N));
      if (i > 0) check("s1_bin", hist_wr_bin, i);
    end

    // Lone requester 2 gets every cycle, then the pointer sits at 3.
    for (int i = 0; i < 5; i++) begin
      step(4'b0100, b1, 1'b1, 1'b0, 3'd2);
      check("s2_grant", req_ready, 4'b0100);
    end
    step('1, b1, 1'b1, 1'b0, 3'd2);
    check("s2_ptr", req_ready, 4'b1000);

    // Core back-pressure with bin 9 pending while requester 1 waits.
    b3 = {6'd0, 6'd0, 6'd9, 6'd0};
    step('0, b3, 1'b1, 1'b0, 3'd1);
    step('0, b3, 1'b1, 1'b0, 3'd1);
    step(4'b0010, b3, 1'b1, 1'b0, 3'd1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, b3, 1'b0, 1'b0, 3'd1);
      check("s3_hold_bin", hist_wr_bin, 9);
      check("s3_no_grant", req_ready, 0);
    end
    step(4'b0010, b3, 1'b1, 1'b0, 3'd1);
    check("s3_resume", req_ready, 4'b0010);
    step('0, b3, 1'b1, 1'b0, 3'd1);

    // Forced dump requested while a write is pending and the core is busy.
    step(4'b0001, b1, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step('1, b1, 1'b0, 1'b1, 3'd0);
      check("s4_no_dump_yet", hist_dump, 0);
    end
    step('1, b1, 1'b1, 1'b1, 3'd0);
    step('1, b1, 1'b1, 1'b1, 3'd0);
    check("s4_dump", hist_dump, 1);
    step('1, b1, 1'b0, 1'b1, 3'd0);
    step('1, b1, 1'b0, 1'b1, 3'd0);
    step('1, b1, 1'b1, 1'b1, 3'd0);
    check("s4_done", dump_done, 1);
    step('1, b1, 1'b1, 1'b1, 3'd0);
    check("s4_no_rearm", req_ready != 0, 1);
    step('0, b1, 1'b1, 1'b0, 3'd0);

    // Reset while waiting for the dump to finish.
    step('0, b1, 1'b1, 1'b0, 3'd0);
    step('0, b1, 1'b1, 1'b1, 3'd0);
    step('0, b1, 1'b1, 1'b1, 3'd0);
    step('0, b1, 1'b0, 1'b1, 3'd0);
    step('0, b1, 1'b0, 1'b1, 3'd0);
    do_reset();
    step('1, b1, 1'b1, 1'b0, 3'd0);
    check("s5_first_grant", req_ready, 4'b0001);

    // Random traffic, back-pressure and dump requests.
    dr_lvl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) dr_lvl = ~dr_lvl;
      step(N'($urandom), (N*W)'($urandom), $urandom_range(0, 9) < 8, dr_lvl,
           3'($urandom_range(0, 7)));
    end
    step('0, b1, 1'b1, 1'b0, 3'd3);
    step('0, b1, 1'b1, 1'b0, 3'd3);
    for (int i = 0; i < 8; i++) step('0, b1, ~hist_ready, 1'b0, 3'd3);
    step('0, b1, 1'b1, 1'b0, 3'd3);

`ifdef HIST_ARB_STATS_EN
    // Saturate requester 3's counter, then clear it with a forced dump.
    for (int i = 0; i < 70000; i++) step(4'b1000, b1, 1'b1, 1'b0, 3'd3);
    step('0, b1, 1'b1, 1'b0, 3'd3);
    check("s6_sat", stat_cnt, 16'hFFFF);
    step('0, b1, 1'b1, 1'b1, 3'd3);
    step('0, b1, 1'b1, 1'b1, 3'd3);
    step('0, b1, 1'b0, 1'b1, 3'd3);
    step('0, b1, 1'b1, 1'b1, 3'd3);
    check("s6_done", dump_done, 1);
    step('0, b1, 1'b1, 1'b0, 3'd3);
    step('0, b1, 1'b1, 1'b0, 3'd3);
    check("s6_cleared", stat_cnt, 0);
`else
    for (int i = 0; i < 20; i++) step(4'b1000, b1, 1'b1, 1'b0, 3'd3);
    check("s6_tied_zero", stat_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hist_req_arbiter.md
# hist_req_arbiter

Shares the histogram core's single bin-increment port among `NUM_REQ` independent sample sources using round-robin arbitration. It absorbs the core's back-pressure during its automatic readout/clear sequence and sequences host-requested forced dumps. Sits between the sample front-ends and the histogram core inside `tt_um_*` top-level glue.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `BIN_W`, 6: bin index width (64 bins).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; all state and outputs clear immediately.
- `req_valid`  in  NUM_REQ  per-requester increment request.
- `req_bin`  in  NUM_REQ*BIN_W  packed bin indices; requester k in bits [k*BIN_W +: BIN_W].
- `req_ready`  out  NUM_REQ  one-hot grant; transfer when `req_valid[k] && req_ready[k]`.
- `hist_wr_en`  out  1  increment valid to core (registered).
- `hist_wr_bin`  out  BIN_W  bin to increment (registered).
- `hist_ready`  in  1  core accepts increments; low during readout/clear.
- `hist_dump`  out  1  one-cycle pulse forcing core readout.
- `dump_req`  in  1  host level request for forced dump.
- `dump_done`  out  1  one-cycle pulse when forced dump completes.
- `stat_sel`  in  3  requester select for statistics readback.
- `stat_cnt`  out  16  grant count of requester `stat_sel`.

## Operation
- Output stage: one-entry register (`hist_wr_en`/`hist_wr_bin`). The core accepts a write when `hist_wr_en && hist_ready`. An unaccepted write holds stable until accepted; writes are never dropped.
- Grant issue condition: state ARB and output register empty or being accepted this cycle. At most one `req_ready` bit per cycle. `req_ready` is combinational from `req_valid`, the pointer, and state.
- Round robin: search starts at `rr_ptr`; after a grant to k, `rr_ptr` <= (k+1) mod NUM_REQ. Reset `rr_ptr` = 0. No grant: pointer unchanged.
- FSM states:
  - ARB: normal arbitration. `dump_req` high -> HOLD; no new grants from that cycle.
  - HOLD: wait until the output register is empty (last write accepted), then pulse `hist_dump` -> WAIT_BUSY.
  - WAIT_BUSY: wait for `hist_ready` low -> WAIT_DONE.
  - WAIT_DONE: wait for `hist_ready` high, pulse `dump_done` -> ARB. A new dump needs `dump_req` deasserted and reasserted (edge-detected in ARB).
- Core-initiated readout (a bin saturates): `hist_ready` drops with FSM in ARB. The pending write holds and new grants stop, because the output register stays full. Arbitration resumes automatically.
- `dump_req` while `hist_ready` is already low: HOLD waits as normal. `hist_dump` is issued only after the held write is accepted.
- Reset mid-dump: returns to ARB, output register empty, no `dump_done`.

## Timing
- Reset values: `req_ready`=0, `hist_wr_en`=0, `hist_wr_bin`=0, `hist_dump`=0, `dump_done`=0, `stat_cnt`=0.
- Latency: handshake in cycle t -> `hist_wr_en` high in t+1.
- Throughput: one increment per cycle while `hist_ready` stays high.
- `hist_dump` fires at the earliest 1 cycle after `dump_req` is sampled in ARB, if no write is pending.

## Configuration
- `HIST_ARB_STATS_EN` defined: per-requester 16-bit grant counters. Each increments on its requester's handshake and saturates at 0xFFFF. They clear on reset and on the `dump_done` pulse. `stat_cnt` is the registered counter selected by `stat_sel`, 1-cycle latency. `stat_sel` >= NUM_REQ returns 0.
- Not defined: counters are absent and `stat_cnt` is tied to 0.

## Structure
- Package `hist_pkg`: `BIN_W` default, FSM state encoding (ARB, HOLD, WAIT_BUSY, WAIT_DONE), stat counter width.
- Sub-module `rr_picker`: combinational rotating-priority one-hot select from a request vector and `rr_ptr`. It is reused by future histogram readout-port sharing.

## Test plan
- Reset, then requesters 0..3 all valid with bins 1,2,3,4 and `hist_ready`=1 -> grants 0,1,2,3,0 on consecutive cycles; `hist_wr_bin` = 1,2,3,4 one cycle later.
- Only requester 2 valid for 5 cycles -> 5 consecutive grants to 2, and `rr_ptr`=3 afterwards.
- `hist_ready` drops the cycle after a write of bin 9 while requester 1 is valid -> `hist_wr_en`=1 with bin 9 held, `req_ready`=0 throughout; when ready returns, bin 9 is accepted once, then requester 1 is granted.
- `dump_req` raised with a write pending and `hist_ready` low for 3 cycles -> `hist_dump` is pulsed only after the pending write is accepted, then the FSM passes WAIT_BUSY/WAIT_DONE -> `dump_done` pulses once; no grants in between.
- `rst_n` asserted during WAIT_DONE -> all outputs are 0 immediately; after release the first grant goes to requester 0.
- With `HIST_ARB_STATS_EN`: 70000 grants to requester 3 -> `stat_cnt`=0xFFFF at `stat_sel`=3; after a forced dump -> 0.
